// File: rtl/rxfifo_arb_pkg.sv
// rtl/rxfifo_arb_pkg.sv - shared types and helpers for the RX FIFO write arbiter
// Purpose: FSM state encoding, arbitration mode constants and a width helper.
// Ports: none (package).
package rxfifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Bits needed to index 'value' items; never returns less than 1 so that
  // single-channel builds still get a legal vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int w = 0; w < 31; w++) begin
      if ((1 << w) < value) r = w + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rxfifo_grant_sel.sv
// rtl/rxfifo_grant_sel.sv - combinational fixed-priority / round-robin grant picker
// Purpose: choose which pending channel gets the next FIFO write.
// Ports:
//   pending     in  NUM_CH  channels holding a word
//   last_grant  in  GW      channel granted most recently (round-robin origin)
//   mode        in  1       0 = fixed priority (ch0 highest), 1 = round-robin
//   grant_valid out 1       at least one channel is pending
//   grant       out GW      selected channel index
module rxfifo_grant_sel
  import rxfifo_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int GW     = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [GW-1:0]     last_grant,
  input  logic              mode,
  output logic              grant_valid,
  output logic [GW-1:0]     grant
);

  logic          lo_valid;
  logic [GW-1:0] lo_grant;
  logic          hi_valid;
  logic [GW-1:0] hi_grant;

  // Scanning downwards leaves the lowest matching index in each result.
  // lo_* is the lowest pending channel overall; hi_* the lowest pending
  // channel above last_grant. Round-robin prefers hi_* and wraps to lo_*,
  // which also covers last_grant itself being the only requester.
  always_comb begin
    lo_valid = 1'b0;
    lo_grant = '0;
    hi_valid = 1'b0;
    hi_grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_valid = 1'b1;
        lo_grant = GW'(i);
        if (GW'(i) > last_grant) begin
          hi_valid = 1'b1;
          hi_grant = GW'(i);
        end
      end
    end
    grant_valid = lo_valid;
    grant       = (mode && hi_valid) ? hi_grant : lo_grant;
  end

endmodule

// File: rtl/rxfifo_wr_arbiter.sv
// rtl/rxfifo_wr_arbiter.sv - multi-channel single-word RX FIFO write arbiter
// Purpose: queue one word per channel, grant one FIFO write at a time, wait
// for ack/overflow/timeout and report per-channel completion status.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   rxfifo_full            FIFO full; no grant issues while high
//   rxfifo_wr_en           one-cycle write strobe per grant
//   rxfifo_dwrite          write data, held until the next grant
//   rxfifo_wr_ack          FIFO accepted the write
//   rxfifo_overflow        FIFO rejected the write (wins over ack)
//   ch_wr_start/ch_wr_data per-channel request pulse and data
//   ch_busy                channel holds a pending word
//   ch_wr_done/ch_wr_err   completion pulse, error flag on overflow/timeout
//   drop_count/ovf_count   saturating counters of drops and aborted writes
module rxfifo_wr_arbiter
  import rxfifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int ARB_MODE    = 0,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rxfifo_full,
  output logic                         rxfifo_wr_en,
  output logic [DATA_WIDTH-1:0]        rxfifo_dwrite,
  input  logic                         rxfifo_wr_ack,
  input  logic                         rxfifo_overflow,
  input  logic [NUM_CH-1:0]            ch_wr_start,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]            ch_busy,
  output logic [NUM_CH-1:0]            ch_wr_done,
  output logic [NUM_CH-1:0]            ch_wr_err,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic [CNT_WIDTH-1:0]         ovf_count
);

  localparam int GW = clog2(NUM_CH);
  localparam int TW = clog2(ACK_TIMEOUT + 1);
  localparam logic          MODE_RR    = (ARB_MODE == ARB_RR);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [NUM_CH-1:0]       pending_q, pending_d;
  logic [DATA_WIDTH-1:0]   data_q [NUM_CH];
  logic [DATA_WIDTH-1:0]   data_d [NUM_CH];
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   dwrite_q, dwrite_d;
  logic [NUM_CH-1:0]       done_q, done_d;
  logic [NUM_CH-1:0]       err_q, err_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic [NUM_CH-1:0]       clear;
  logic                    sel_valid;
  logic [GW-1:0]           sel_grant;

  rxfifo_grant_sel #(
    .NUM_CH (NUM_CH),
    .GW     (GW)
  ) u_grant_sel (
    .pending     (pending_q),
    .last_grant  (last_grant_q),
    .mode        (MODE_RR),
    .grant_valid (sel_valid),
    .grant       (sel_grant)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    data_d       = data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    wr_en_d      = 1'b0;
    dwrite_d     = dwrite_q;
    done_d       = '0;
    err_d        = '0;
    drop_cnt_d   = drop_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;
    clear        = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid && !rxfifo_full) begin
          wr_en_d      = 1'b1;
          dwrite_d     = data_q[sel_grant];
          grant_d      = sel_grant;
          last_grant_d = sel_grant;
          timer_d      = '0;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        // Overflow is checked before ack so a simultaneous pair reports error.
        if (rxfifo_overflow || (timer_q == TIMER_LAST)) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          clear[grant_q]  = 1'b1;
          if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
          state_d = ST_DONE;
        end else if (rxfifo_wr_ack) begin
          done_d[grant_q] = 1'b1;
          clear[grant_q]  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A start landing on the completion cycle refills the slot instead of
    // being dropped.
    pending_d = pending_q & ~clear;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_wr_start[i]) begin
        if (!pending_q[i] || clear[i]) begin
          pending_d[i] = 1'b1;
          data_d[i]    = ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (drop_cnt_d != '1) begin
          drop_cnt_d = drop_cnt_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
      grant_q      <= '0;
      last_grant_q <= '0;
      timer_q      <= '0;
      wr_en_q      <= 1'b0;
      dwrite_q     <= '0;
      done_q       <= '0;
      err_q        <= '0;
      drop_cnt_q   <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      for (int i = 0; i < NUM_CH; i++) data_q[i] <= data_d[i];
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      wr_en_q      <= wr_en_d;
      dwrite_q     <= dwrite_d;
      done_q       <= done_d;
      err_q        <= err_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign rxfifo_wr_en  = wr_en_q;
  assign rxfifo_dwrite = dwrite_q;
  assign ch_busy       = pending_q;
  assign ch_wr_done    = done_q;
  assign ch_wr_err     = err_q;
  assign drop_count    = drop_cnt_q;
  assign ovf_count     = ovf_cnt_q;

endmodule

// File: tb/tb_rxfifo_wr_arbiter.sv
// tb/tb_rxfifo_wr_arbiter.sv - self-checking bench for rxfifo_wr_arbiter
module tb_rxfifo_wr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // DUT A: 2 channels, fixed priority
  logic        a_full = 1'b0, a_ack = 1'b0, a_ovf = 1'b0;
  logic [1:0]  a_start = '0;
  logic [63:0] a_data = '0;
  logic        a_wr_en;
  logic [31:0] a_dwrite;
  logic [1:0]  a_busy, a_done, a_err;
  logic [15:0] a_drop, a_ovfc;

  // DUT B: 4 channels, round-robin
  logic         b_full = 1'b0, b_ack = 1'b0, b_ovf = 1'b0;
  logic [3:0]   b_start = '0;
  logic [127:0] b_data = '0;
  logic         b_wr_en;
  logic [31:0]  b_dwrite;
  logic [3:0]   b_busy, b_done, b_err;
  logic [15:0]  b_drop, b_ovfc;

  rxfifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_CH(2), .ARB_MODE(0), .ACK_TIMEOUT(15), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .rxfifo_full(a_full), .rxfifo_wr_en(a_wr_en), .rxfifo_dwrite(a_dwrite),
    .rxfifo_wr_ack(a_ack), .rxfifo_overflow(a_ovf), .ch_wr_start(a_start), .ch_wr_data(a_data),
    .ch_busy(a_busy), .ch_wr_done(a_done), .ch_wr_err(a_err), .drop_count(a_drop), .ovf_count(a_ovfc));

  rxfifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_CH(4), .ARB_MODE(1), .ACK_TIMEOUT(15), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .rxfifo_full(b_full), .rxfifo_wr_en(b_wr_en), .rxfifo_dwrite(b_dwrite),
    .rxfifo_wr_ack(b_ack), .rxfifo_overflow(b_ovf), .ch_wr_start(b_start), .ch_wr_data(b_data),
    .ch_busy(b_busy), .ch_wr_done(b_done), .ch_wr_err(b_err), .drop_count(b_drop), .ovf_count(b_ovfc));

  // FIFO responders: answer one cycle after the strobe. resp 0=ack, 1=overflow, 2=silent.
  int a_resp = 0;
  logic a_seen = 1'b0;
  int a_ack_cyc = -100;
  initial forever begin
    @(negedge clk);
    a_ack = 1'b0;
    a_ovf = 1'b0;
    if (a_seen && !reset) begin
      if (a_resp == 0) begin a_ack = 1'b1; a_ack_cyc = cyc; end
      else if (a_resp == 1) begin a_ovf = 1'b1; a_ack_cyc = cyc; end
    end
    a_seen = a_wr_en;
  end

  logic b_seen = 1'b0;
  initial forever begin
    @(negedge clk);
    b_ack = 1'b0;
    if (b_seen && !reset) b_ack = 1'b1;
    b_seen = b_wr_en;
  end

  // Scoreboards: expected write words are queued when stimulus is driven.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int a_wr_cnt = 0, a_wr_cyc = -100;
  int a_wr_times[$];
  int b_wr_cnt = 0;

  initial begin : mon_a
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (a_wr_en === 1'b1) begin
        a_wr_cnt++;
        a_wr_cyc = cyc;
        a_wr_times.push_back(cyc);
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_write: dwrite=%h, no write expected", a_dwrite);
        end else begin
          e = qa.pop_front();
          if (a_dwrite !== e) begin
            errors++;
            $display("FAIL a_dwrite: got %h expected %h", a_dwrite, e);
          end
        end
      end
    end
  end

  initial begin : mon_b
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (b_wr_en === 1'b1) begin
        b_wr_cnt++;
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_write: dwrite=%h, no write expected", b_dwrite);
        end else begin
          e = qb.pop_front();
          if (b_dwrite !== e) begin
            errors++;
            $display("FAIL b_grant_order: got %h expected %h", b_dwrite, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", a_wr_en); end
    checks++; if (a_dwrite !== 32'h0) begin errors++; $display("FAIL reset_dwrite: got %h expected 0", a_dwrite); end
    checks++; if ({a_busy, a_done, a_err} !== 6'h0) begin errors++; $display("FAIL reset_status: got %b expected 0", {a_busy, a_done, a_err}); end
    checks++; if ({a_drop, a_ovfc} !== 32'h0) begin errors++; $display("FAIL reset_counters: got %h expected 0", {a_drop, a_ovfc}); end
    checks++; if ({b_wr_en, b_busy} !== 5'h0) begin errors++; $display("FAIL reset_b: got %b expected 0", {b_wr_en, b_busy}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int s, n, dcyc, c0;
    logic [1:0] dv, ev, bv;
    @(negedge clk);
    s = cyc; c0 = a_wr_cnt;
    a_data[63:32] = 32'hA5A5_0001; a_start = 2'b10; qa.push_back(32'hA5A5_0001);
    @(negedge clk);
    a_start = '0;
    checks++; if (a_busy !== 2'b10) begin errors++; $display("FAIL single_busy: got %b expected 10", a_busy); end
    n = 0;
    while (a_done === 2'b00 && n < 30) begin @(negedge clk); n++; end
    dcyc = cyc; dv = a_done; ev = a_err; bv = a_busy;
    checks++; if (dv !== 2'b10) begin errors++; $display("FAIL single_done: got %b expected 10", dv); end
    checks++; if (ev !== 2'b00) begin errors++; $display("FAIL single_err: got %b expected 00", ev); end
    checks++; if (dcyc !== a_ack_cyc + 1) begin errors++; $display("FAIL single_done_latency: got cycle %0d expected %0d", dcyc, a_ack_cyc + 1); end
    checks++; if (bv !== 2'b00) begin errors++; $display("FAIL single_busy_clear: got %b expected 00", bv); end
    checks++; if (a_wr_cyc !== s + 2) begin errors++; $display("FAIL single_wr_latency: got cycle %0d expected %0d", a_wr_cyc, s + 2); end
    @(negedge clk);
    checks++; if (a_done !== 2'b00) begin errors++; $display("FAIL single_done_width: got %b expected 00", a_done); end
    repeat (3) @(negedge clk);
    checks++; if (a_wr_cnt !== c0 + 1) begin errors++; $display("FAIL single_wr_count: got %0d expected %0d", a_wr_cnt - c0, 1); end
  endtask

  task automatic test_same_cycle();
    int s, t0, n;
    @(negedge clk);
    s = cyc; t0 = a_wr_times.size();
    a_data = {32'h0000_0020, 32'h0000_0010}; a_start = 2'b11;
    qa.push_back(32'h0000_0010); qa.push_back(32'h0000_0020);
    @(negedge clk);
    a_start = '0;
    n = 0;
    while (a_wr_times.size() < t0 + 2 && n < 40) begin @(negedge clk); n++; end
    if (a_wr_times.size() >= t0 + 2) begin
      checks++; if (a_wr_times[t0] !== s + 2) begin errors++; $display("FAIL same_first_wr: got cycle %0d expected %0d", a_wr_times[t0], s + 2); end
      checks++; if (a_wr_times[t0+1] - a_wr_times[t0] !== 4) begin errors++; $display("FAIL same_spacing: got %0d expected 4", a_wr_times[t0+1] - a_wr_times[t0]); end
    end else begin
      checks++; errors++; $display("FAIL same_writes: got %0d writes expected 2", a_wr_times.size() - t0);
    end
    n = 0;
    while (a_busy !== 2'b00 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full();
    int f, n, c0;
    @(negedge clk);
    c0 = a_wr_cnt;
    a_full = 1'b1; a_data[31:0] = 32'h0000_0033; a_start = 2'b01; qa.push_back(32'h0000_0033);
    @(negedge clk);
    a_start = '0;
    repeat (9) @(negedge clk);
    checks++; if (a_wr_cnt !== c0) begin errors++; $display("FAIL full_no_write: got %0d writes expected 0", a_wr_cnt - c0); end
    checks++; if (a_busy !== 2'b01) begin errors++; $display("FAIL full_busy: got %b expected 01", a_busy); end
    f = cyc;
    a_full = 1'b0;
    n = 0;
    while (a_busy !== 2'b00 && n < 20) begin @(negedge clk); n++; end
    checks++; if (a_wr_cyc !== f + 1) begin errors++; $display("FAIL full_release: got cycle %0d expected %0d", a_wr_cyc, f + 1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    int n;
    logic [1:0] dv, ev;
    a_resp = 1;
    @(negedge clk);
    a_data[31:0] = 32'h0000_0044; a_start = 2'b01; qa.push_back(32'h0000_0044);
    @(negedge clk);
    a_start = '0;
    n = 0;
    while (a_done === 2'b00 && n < 30) begin @(negedge clk); n++; end
    dv = a_done; ev = a_err;
    checks++; if (dv !== 2'b01) begin errors++; $display("FAIL ovf_done: got %b expected 01", dv); end
    checks++; if (ev !== 2'b01) begin errors++; $display("FAIL ovf_err: got %b expected 01", ev); end
    @(negedge clk);
    checks++; if (a_ovfc !== 16'd1) begin errors++; $display("FAIL ovf_count: got %0d expected 1", a_ovfc); end
    a_resp = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, dcyc;
    logic [1:0] dv, ev;
    a_resp = 2;
    @(negedge clk);
    a_data[31:0] = 32'h0000_0055; a_start = 2'b01; qa.push_back(32'h0000_0055);
    @(negedge clk);
    a_start = '0;
    n = 0;
    while (a_done === 2'b00 && n < 40) begin @(negedge clk); n++; end
    dcyc = cyc; dv = a_done; ev = a_err;
    checks++; if (dv !== 2'b01 || ev !== 2'b01) begin errors++; $display("FAIL timeout_done_err: got %b/%b expected 01/01", dv, ev); end
    checks++; if (dcyc - a_wr_cyc !== 15) begin errors++; $display("FAIL timeout_latency: got %0d expected 15", dcyc - a_wr_cyc); end
    @(negedge clk);
    checks++; if (a_ovfc !== 16'd2) begin errors++; $display("FAIL timeout_ovf_count: got %0d expected 2", a_ovfc); end
    a_resp = 0;
    a_data[63:32] = 32'h0000_0066; a_start = 2'b10; qa.push_back(32'h0000_0066);
    @(negedge clk);
    a_start = '0;
    n = 0;
    while (a_done === 2'b00 && n < 30) begin @(negedge clk); n++; end
    dv = a_done; ev = a_err;
    checks++; if (dv !== 2'b10 || ev !== 2'b00) begin errors++; $display("FAIL timeout_next_grant: got %b/%b expected 10/00", dv, ev); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop();
    int n;
    @(negedge clk);
    a_data[31:0] = 32'h0000_0077; a_start = 2'b01; qa.push_back(32'h0000_0077);
    @(negedge clk);
    a_data[31:0] = 32'h0000_0078; a_start = 2'b01;
    @(negedge clk);
    a_start = '0;
    checks++; if (a_drop !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", a_drop); end
    n = 0;
    while (a_busy !== 2'b00 && n < 30) begin @(negedge clk); n++; end
    checks++; if (a_busy !== 2'b00) begin errors++; $display("FAIL drop_busy_clear: got %b expected 00", a_busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_coincident();
    int n;
    logic [15:0] d0;
    d0 = a_drop;
    @(negedge clk);
    a_data[31:0] = 32'h0000_0081; a_start = 2'b01; qa.push_back(32'h0000_0081);
    @(negedge clk);
    a_start = '0;
    n = 0;
    while (a_wr_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (a_wr_en !== 1'b1) begin errors++; $display("FAIL coinc_wr_seen: got %b expected 1", a_wr_en); end
    @(negedge clk);
    a_data[31:0] = 32'h0000_0082; a_start = 2'b01; qa.push_back(32'h0000_0082);
    @(negedge clk);
    a_start = '0;
    checks++; if (a_done !== 2'b01) begin errors++; $display("FAIL coinc_done: got %b expected 01", a_done); end
    checks++; if (a_busy !== 2'b01) begin errors++; $display("FAIL coinc_busy: got %b expected 01", a_busy); end
    checks++; if (a_drop !== d0) begin errors++; $display("FAIL coinc_drop: got %0d expected %0d", a_drop, d0); end
    @(negedge clk);
    n = 0;
    while (a_done === 2'b00 && n < 30) begin @(negedge clk); n++; end
    checks++; if (a_done !== 2'b01 || a_busy !== 2'b00) begin errors++; $display("FAIL coinc_second: got done %b busy %b expected 01/00", a_done, a_busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rr();
    int reqs [4];
    int n, c0, done_total;
    c0 = b_wr_cnt; done_total = 0;
    for (int k = 0; k < 8; k++) qb.push_back(32'hC0DE_0000 + 32'(k % 4));
    @(negedge clk);
    b_data = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    b_start = 4'b0001; reqs[0] = 1; reqs[1] = 0; reqs[2] = 0; reqs[3] = 0;
    @(negedge clk);
    b_start = 4'b1110; reqs[1] = 1; reqs[2] = 1; reqs[3] = 1;
    n = 0;
    while (b_wr_cnt - c0 < 8 && n < 300) begin
      @(negedge clk);
      n++;
      done_total += $countones(b_done);
      b_start = '0;
      for (int i = 0; i < 4; i++) begin
        if (!b_busy[i] && reqs[i] < 2) begin b_start[i] = 1'b1; reqs[i]++; end
      end
    end
    b_start = '0;
    n = 0;
    while (b_busy !== 4'h0 && n < 40) begin @(negedge clk); n++; done_total += $countones(b_done); end
    repeat (3) @(negedge clk);
    checks++; if (b_wr_cnt - c0 !== 8) begin errors++; $display("FAIL rr_writes: got %0d expected 8", b_wr_cnt - c0); end
    checks++; if (qb.size() !== 0) begin errors++; $display("FAIL rr_pending_expect: got %0d left expected 0", qb.size()); end
    checks++; if (b_drop !== 16'd0) begin errors++; $display("FAIL rr_drops: got %0d expected 0", b_drop); end
    checks++; if (done_total !== 8) begin errors++; $display("FAIL rr_done_pulses: got %0d expected 8", done_total); end
  endtask

  task automatic test_reset_mid();
    int n, dn, c0;
    a_resp = 2;
    @(negedge clk);
    a_data[63:32] = 32'h0000_0099; a_start = 2'b10; qa.push_back(32'h0000_0099);
    @(negedge clk);
    a_start = '0;
    n = 0;
    while (a_wr_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    #2 reset = 1'b1;
    #1;
    checks++; if (a_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: got %b expected 0", a_wr_en); end
    checks++; if (a_dwrite !== 32'h0) begin errors++; $display("FAIL rstmid_dwrite: got %h expected 0", a_dwrite); end
    checks++; if ({a_busy, a_done, a_err} !== 6'h0) begin errors++; $display("FAIL rstmid_status: got %b expected 0", {a_busy, a_done, a_err}); end
    checks++; if ({a_drop, a_ovfc} !== 32'h0) begin errors++; $display("FAIL rstmid_counters: got %h expected 0", {a_drop, a_ovfc}); end
    @(negedge clk);
    reset = 1'b0;
    a_resp = 0;
    c0 = a_wr_cnt; dn = 0;
    repeat (20) begin @(negedge clk); if (a_done !== 2'b00) dn++; end
    checks++; if (dn !== 0 || a_wr_cnt !== c0) begin errors++; $display("FAIL rstmid_no_done: got %0d done %0d writes expected 0/0", dn, a_wr_cnt - c0); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_same_cycle();
    test_full();
    test_overflow();
    test_timeout();
    test_drop();
    test_coincident();
    test_rr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rxfifo_wr_arbiter.md
Name: rxfifo_wr_arbiter

Overview:
Parametrised successor to the single-word RX FIFO write machine. It accepts single-word write requests from NUM_CH independent sources (descriptor engine, Linux path, beacon/TDMA logic, ...), queues one word per channel, and arbitrates between them with fixed-priority or round-robin arbitration. It performs one FIFO write per grant, waits for the FIFO ack, and reports completion, overflow and timeout status per channel. It sits between the RX-side producers and the Xilinx RX FIFO write port.

Parameters:
DATA_WIDTH, 32, width of the FIFO word and of each channel's data.
NUM_CH, 2, number of requesting channels (1..8).
ARB_MODE, 0, 0 = fixed priority (ch0 highest), 1 = round-robin.
ACK_TIMEOUT, 15, cycles to wait for rxfifo_wr_ack/rxfifo_overflow before aborting (1..255).
CNT_WIDTH, 16, width of the status counters.

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
rxfifo_full  in  1  FIFO full flag
rxfifo_wr_en  out  1  FIFO write strobe, one cycle per grant
rxfifo_dwrite  out  DATA_WIDTH  FIFO write data
rxfifo_wr_ack  in  1  FIFO write accepted
rxfifo_overflow  in  1  FIFO write rejected
ch_wr_start  in  NUM_CH  per-channel request pulse
ch_wr_data  in  NUM_CH*DATA_WIDTH  per-channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
ch_busy  out  NUM_CH  channel holds a pending word
ch_wr_done  out  NUM_CH  one-cycle completion pulse
ch_wr_err  out  NUM_CH  one-cycle pulse coincident with ch_wr_done on overflow or timeout
drop_count  out  CNT_WIDTH  requests rejected because the channel was busy
ovf_count  out  CNT_WIDTH  overflow and timeout aborts

Behaviour:
- Reset: asynchronous, active-high. All outputs, pending registers, counters, the RR pointer and state are cleared to 0, and rxfifo_wr_en drops immediately. A reset mid-transaction discards every pending word with no done pulse.
- Capture: ch_wr_start[i] with pending[i]=0 latches the data and sets pending[i] on the next edge. ch_busy = pending.
- Busy channel: ch_wr_start[i] with pending[i]=1 is dropped and drop_count increments by 1.
- Start on the completion cycle: if ch_wr_start[i] arrives on the cycle pending[i] clears, the new word is captured, pending[i] stays 1, and nothing is dropped.
- Counters saturate at all-ones; they do not wrap.
- FSM IDLE: when any pending bit is set and rxfifo_full=0 on a cycle, select grant g. On the next edge: rxfifo_dwrite <= data[g], rxfifo_wr_en <= 1, timer <= 0, go to WAIT_ACK. If rxfifo_full=1, stay in IDLE and issue nothing.
- FSM WAIT_ACK: rxfifo_wr_en <= 0 on the first cycle, so the strobe is exactly one cycle. Outcomes:
  - rxfifo_wr_ack: pulse ch_wr_done[g], clear pending[g], go to DONE.
  - rxfifo_overflow: pulse ch_wr_done[g] and ch_wr_err[g], clear pending[g], ovf_count+1, go to DONE.
  - ack and overflow on the same cycle: overflow wins.
  - timer reaches ACK_TIMEOUT: same handling as overflow.
- FSM DONE: one-cycle gap for done/err pulse alignment, then return to IDLE.
- Arbitration, fixed priority: lowest-index pending channel wins.
- Arbitration, round-robin: search starts at last_grant+1 modulo NUM_CH; last_grant updates when the grant issues.
- Latency: start at edge T gives pending at T+1, wr_en high T+1..T+2, ack no earlier than T+3, done pulse the cycle after ack. Minimum spacing between back-to-back grants is 4 cycles.
- rxfifo_dwrite holds its value until the next grant.

Decomposition:
- Package rxfifo_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT_ACK=2'd1, ST_DONE=2'd2;
  - ARB_FIXED=0 and ARB_RR=1;
  - a clog2 function for grant and timer widths.
- Sub-module rxfifo_grant_sel holds the combinational priority/RR picker: inputs pending, last_grant, mode; outputs grant_valid and grant index. It is instantiated once.

Test Plan:
- NUM_CH=2, fixed mode, single start on ch1 with data 0xA5A5_0001, FIFO acks 1 cycle after wr_en -> exactly one wr_en pulse with dwrite=0xA5A5_0001; ch_wr_done[1] pulses the cycle after ack; err=0; busy[1] clears.
- Fixed mode, ch0 and ch1 start on the same cycle with data 0x10 and 0x20 -> writes occur in order 0x10 then 0x20, 4 cycles apart.
- RR mode, NUM_CH=4, all channels continuously re-requested over 8 grants -> grant order 0,1,2,3,0,1,2,3; no drops.
- rxfifo_full held high for 10 cycles with ch0 pending -> no wr_en while full; write issues the cycle after full deasserts. Separately, overflow asserted instead of ack -> done+err pulse on ch0 and ovf_count=1.
- FIFO never acks, ACK_TIMEOUT=15 -> done+err 15 cycles after entering WAIT_ACK; ovf_count increments; the next grant proceeds.
- Second start on busy ch0 -> drop_count=1. Start coincident with completion -> new word captured, drop_count unchanged. Reset asserted during WAIT_ACK -> all outputs 0 asynchronously and no done pulse.
